id_ex_stage_reg: RTL and testbench

//  Decode->Execute pipeline register of the 5-stage RISC-V core. Captures main_decoder

---
 rtl/id_ex_stage_reg.sv | 125 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// Decode->Execute pipeline register with load-use hazard detection, branch flush
// and saturating bubble/flush performance counters.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             ALUSrcD,
    input  logic             MemWriteD,
    input  logic             ResultSrcD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [RAW-1:0]   RS1D,
    input  logic [RAW-1:0]   RS2D,
    input  logic [RAW-1:0]   RDD,
    input  logic             ValidD,
    input  logic             FlushE,
    output logic             RegWriteE,
    output logic             ALUSrcE,
    output logic             MemWriteE,
    output logic             ResultSrcE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [RAW-1:0]   RS1E,
    output logic [RAW-1:0]   RS2E,
    output logic [RAW-1:0]   RDE,
    output logic             ValidE,
    output logic             StallF,
    output logic             StallD,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] cntMax = '1;

    logic loadUse;
    logic insertBubble;

    // rs2 is compared for every opcode; a false stall only costs one cycle.
    assign loadUse = ValidE & ResultSrcE & RegWriteE & (RDE != '0) & ValidD
                     & ((RDE == RS1D) | (RDE == RS2D));

    assign StallF = loadUse & ~FlushE & ~rst;
    assign StallD = loadUse & ~FlushE & ~rst;

    assign insertBubble = FlushE | loadUse | ~ValidD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            RS1E     <= '0;
            RS2E     <= '0;
            RDE      <= '0;
        end else begin
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            RS1E     <= RS1D;
            RS2E     <= RS2D;
            RDE      <= RDD;
        end
    end

    // A bubble only needs its side-effect controls cleared; data fields are don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ValidE      <= 1'b0;
        end else if (insertBubble) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ValidE      <= 1'b0;
        end else begin
            RegWriteE   <= RegWriteD;
            ALUSrcE     <= ALUSrcD;
            MemWriteE   <= MemWriteD;
            ResultSrcE  <= ResultSrcD;
            BranchE     <= BranchD;
            ALUControlE <= ALUControlD;
            ValidE      <= ValidD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (FlushE) begin
            if (ValidD && (flush_cnt != cntMax)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (loadUse && (bubble_cnt != cntMax)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed scoreboard bench for id_ex_stage_reg; a second instance with 2-bit
// counters exercises counter saturation alongside the default instance.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        regWrite;
        logic        aluSrc;
        logic        memWrite;
        logic        resultSrc;
        logic        branch;
        logic [2:0]  aluCtl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } stageT;

    typedef struct {
        stageT e;
        int    bub;
        int    fl;
    } expT;

    expT   scoreQ[$];
    stageT modelE;
    int    modelBub;
    int    modelFl;
    int    compared   = 0;
    int    mismatched = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, ValidD, FlushE;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  RS1D, RS2D, RDD;

    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE, StallF, StallD;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        sRegWriteE, sALUSrcE, sMemWriteE, sResultSrcE, sBranchE, sValidE, sStallF, sStallD;
    logic [2:0]  sALUControlE;
    logic [31:0] sRD1E, sRD2E, sImmExtE, sPCE, sPCPlus4E;
    logic [4:0]  sRS1E, sRS2E, sRDE;
    logic [1:0]  satBubble, satFlush;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
        .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RS1D(RS1D), .RS2D(RS2D), .RDD(RDD), .ValidD(ValidD), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .ValidE(ValidE),
        .StallF(StallF), .StallD(StallD),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
        .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RS1D(RS1D), .RS2D(RS2D), .RDD(RDD), .ValidD(ValidD), .FlushE(FlushE),
        .RegWriteE(sRegWriteE), .ALUSrcE(sALUSrcE), .MemWriteE(sMemWriteE),
        .ResultSrcE(sResultSrcE), .BranchE(sBranchE), .ALUControlE(sALUControlE),
        .RD1E(sRD1E), .RD2E(sRD2E), .ImmExtE(sImmExtE), .PCE(sPCE), .PCPlus4E(sPCPlus4E),
        .RS1E(sRS1E), .RS2E(sRS2E), .RDE(sRDE), .ValidE(sValidE),
        .StallF(sStallF), .StallD(sStallD),
        .bubble_cnt(satBubble), .flush_cnt(satFlush)
    );

    function automatic stageT mkInstr(input logic rw, input logic as, input logic mw,
                                      input logic rsrc, input logic br, input logic [2:0] alu,
                                      input logic [31:0] rd1, input logic [31:0] rd2,
                                      input logic [31:0] imm, input logic [31:0] pc,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic v);
        stageT s;
        s.regWrite  = rw;
        s.aluSrc    = as;
        s.memWrite  = mw;
        s.resultSrc = rsrc;
        s.branch    = br;
        s.aluCtl    = alu;
        s.rd1       = rd1;
        s.rd2       = rd2;
        s.imm       = imm;
        s.pc        = pc;
        s.pcPlus4   = pc + 32'd4;
        s.rs1       = rs1;
        s.rs2       = rs2;
        s.rd        = rd;
        s.valid     = v;
        return s;
    endfunction

    function automatic logic [63:0] sat(input int v, input int m);
        return (v > m) ? 64'(m) : 64'(v);
    endfunction

    task automatic driveD(input stageT d, input logic flush);
        RegWriteD   = d.regWrite;
        ALUSrcD     = d.aluSrc;
        MemWriteD   = d.memWrite;
        ResultSrcD  = d.resultSrc;
        BranchD     = d.branch;
        ALUControlD = d.aluCtl;
        RD1D        = d.rd1;
        RD2D        = d.rd2;
        ImmExtD     = d.imm;
        PCD         = d.pc;
        PCPlus4D    = d.pcPlus4;
        RS1D        = d.rs1;
        RS2D        = d.rs2;
        RDD         = d.rd;
        ValidD      = d.valid;
        FlushE      = flush;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic compareE(input string tag, input expT x);
        checkOutput({tag, ".ctrl"},
            64'({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, ValidE}),
            64'({x.e.regWrite, x.e.aluSrc, x.e.memWrite, x.e.resultSrc, x.e.branch,
                 x.e.aluCtl, x.e.valid}));
        checkOutput({tag, ".RD1E"}, 64'(RD1E), 64'(x.e.rd1));
        checkOutput({tag, ".RD2E"}, 64'(RD2E), 64'(x.e.rd2));
        checkOutput({tag, ".ImmExtE"}, 64'(ImmExtE), 64'(x.e.imm));
        checkOutput({tag, ".PCE"}, 64'(PCE), 64'(x.e.pc));
        checkOutput({tag, ".PCPlus4E"}, 64'(PCPlus4E), 64'(x.e.pcPlus4));
        checkOutput({tag, ".regIdx"}, 64'({RS1E, RS2E, RDE}), 64'({x.e.rs1, x.e.rs2, x.e.rd}));
        checkOutput({tag, ".bubble_cnt"}, 64'(bubble_cnt), sat(x.bub, 65535));
        checkOutput({tag, ".flush_cnt"}, 64'(flush_cnt), sat(x.fl, 65535));
        checkOutput({tag, ".satBubble"}, 64'(satBubble), sat(x.bub, 3));
        checkOutput({tag, ".satFlush"}, 64'(satFlush), sat(x.fl, 3));
    endtask

    // One clock of stimulus: stall is checked against the directed expectation,
    // the E contents against the scoreboard entry pushed for this cycle.
    task automatic applyStimulus(input string tag, input stageT d, input logic flush,
                                 input logic expStall);
        logic  lu;
        stageT n;
        expT   x;
        driveD(d, flush);
        #1;
        checkOutput({tag, ".StallF"}, 64'(StallF), 64'(expStall));
        checkOutput({tag, ".StallD"}, 64'(StallD), 64'(expStall));
        lu = modelE.valid & modelE.resultSrc & modelE.regWrite & (modelE.rd != 5'd0) & d.valid
             & ((modelE.rd == d.rs1) | (modelE.rd == d.rs2));
        n = d;
        if (flush || lu || !d.valid) begin
            n.regWrite  = 1'b0;
            n.aluSrc    = 1'b0;
            n.memWrite  = 1'b0;
            n.resultSrc = 1'b0;
            n.branch    = 1'b0;
            n.aluCtl    = 3'b000;
            n.valid     = 1'b0;
        end
        if (flush) begin
            if (d.valid) modelFl++;
        end else if (lu) begin
            modelBub++;
        end
        modelE = n;
        x.e    = n;
        x.bub  = modelBub;
        x.fl   = modelFl;
        scoreQ.push_back(x);
        @(posedge clk);
        #1;
        if (scoreQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s.scoreboard: observed empty queue expected one entry", tag);
        end else begin
            compareE(tag, scoreQ.pop_front());
        end
    endtask

    task automatic applyReset(input string tag);
        expT z;
        z.e   = '0;
        z.bub = 0;
        z.fl  = 0;
        rst = 1'b1;
        #1;
        compareE({tag, ".async"}, z);
        checkOutput({tag, ".StallF"}, 64'(StallF), 64'd0);
        checkOutput({tag, ".StallD"}, 64'(StallD), 64'd0);
        modelE   = '0;
        modelBub = 0;
        modelFl  = 0;
        scoreQ.delete();
        @(posedge clk);
        #1;
        compareE({tag, ".held"}, z);
        rst = 1'b0;
    endtask

    initial begin
        stageT addI, ldI, depI;
        driveD(mkInstr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       3'($urandom), $urandom, $urandom, $urandom, $urandom,
                       5'($urandom), 5'($urandom), 5'($urandom), 1'b1), 1'b0);
        applyReset("reset");

        addI = mkInstr(1, 0, 0, 0, 0, 3'b000, 32'd5, 32'd7, 32'd0, 32'h100, 5'd1, 5'd2, 5'd3, 1);
        applyStimulus("add", addI, 1'b0, 1'b0);
        checkOutput("add.RD1E.const", 64'(RD1E), 64'd5);
        checkOutput("add.RD2E.const", 64'(RD2E), 64'd7);

        ldI  = mkInstr(1, 1, 0, 1, 0, 3'b000, 32'h40, 32'h0, 32'd16, 32'h104, 5'd2, 5'd0, 5'd5, 1);
        depI = mkInstr(1, 0, 0, 0, 0, 3'b010, 32'h11, 32'h22, 32'd0, 32'h108, 5'd5, 5'd4, 5'd6, 1);
        applyStimulus("lw", ldI, 1'b0, 1'b0);
        applyStimulus("luStall", depI, 1'b0, 1'b1);
        checkOutput("luStall.ValidE.const", 64'(ValidE), 64'd0);
        checkOutput("luStall.bubble.const", 64'(bubble_cnt), 64'd1);
        applyStimulus("luEnter", depI, 1'b0, 1'b0);
        checkOutput("luEnter.RDE.const", 64'(RDE), 64'd6);

        ldI.rd = 5'd0;
        applyStimulus("lwX0", ldI, 1'b0, 1'b0);
        depI.rs1 = 5'd0;
        depI.rs2 = 5'd0;
        applyStimulus("x0Dep", depI, 1'b0, 1'b0);
        ldI.rd = 5'd5;
        applyStimulus("lwX5", ldI, 1'b0, 1'b0);
        depI = mkInstr(1, 1, 1, 1, 1, 3'b111, 32'h1, 32'h2, 32'h3, 32'h10c, 5'd5, 5'd5, 5'd7, 0);
        applyStimulus("invalidD", depI, 1'b0, 1'b0);
        checkOutput("invalidD.ctrl.const", 64'({RegWriteE, MemWriteE, ValidE}), 64'd0);

        applyStimulus("lwFl", ldI, 1'b0, 1'b0);
        depI = mkInstr(0, 0, 1, 0, 0, 3'b000, 32'h9, 32'h8, 32'h4, 32'h110, 5'd1, 5'd5, 5'd0, 1);
        applyStimulus("flushLu", depI, 1'b1, 1'b0);
        checkOutput("flushLu.flush.const", 64'(flush_cnt), 64'd1);
        checkOutput("flushLu.bubble.const", 64'(bubble_cnt), 64'd1);

        ldI  = mkInstr(1, 1, 0, 1, 0, 3'b000, 32'h80, 32'h0, 32'd8, 32'h200, 5'd1, 5'd0, 5'd7, 1);
        depI = mkInstr(1, 0, 0, 0, 0, 3'b001, 32'h3, 32'h4, 32'd0, 32'h204, 5'd7, 5'd2, 5'd8, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("satLoad", ldI, 1'b0, 1'b0);
            applyStimulus("satStall", depI, 1'b0, 1'b1);
            applyStimulus("satEnter", depI, 1'b0, 1'b0);
        end
        checkOutput("sat.satBubble.const", 64'(satBubble), 64'd3);
        checkOutput("sat.bubble.const", 64'(bubble_cnt), 64'd6);

        ldI.rd = 5'd9;
        depI.rs1 = 5'd9;
        applyStimulus("midLoad", ldI, 1'b0, 1'b0);
        driveD(depI, 1'b0);
        #1;
        checkOutput("midStall.StallF.const", 64'(StallF), 64'd1);
        applyReset("midReset");
        applyStimulus("postReset", depI, 1'b0, 1'b0);
        checkOutput("postReset.ValidE.const", 64'(ValidE), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
